// File: rtl/csr_file.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : csr_file (with csr_pkg)
//  Description : Machine-mode CSR file in writeback: atomic CSRRW/RS/RC,
//                64-bit mcycle/minstret, registered ready/valid response.
//  Revision    : 1.0 - initial release
// ============================================================================

package csr_pkg;
    typedef enum logic [1:0] {
        CSR_WRITE_NONE = 2'd0,
        CSR_WRITE_RW   = 2'd1,
        CSR_WRITE_RS   = 2'd2,
        CSR_WRITE_RC   = 2'd3
    } csr_write_func_e;

    typedef enum logic {
        CSR_SRC_RS1  = 1'b0,
        CSR_SRC_UIMM = 1'b1
    } csr_src_e;

    typedef struct packed {
        logic            read_enable;
        logic            write_enable;
        csr_src_e        input_select;
        csr_write_func_e write_func;
    } csr_params_t;
endpackage

module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  csr_params_t req_params,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_rs1_value,
    input  logic [4:0]  req_uimm,
    input  logic        retire,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_illegal,
    output logic        mstatus_mie,
    output logic [31:0] mtvec_base
);

    localparam logic [11:0] c_ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] c_ADDR_MISA      = 12'h301;
    localparam logic [11:0] c_ADDR_MIE       = 12'h304;
    localparam logic [11:0] c_ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] c_ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_ADDR_MEPC      = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] c_ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] c_ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] c_ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] c_ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] c_ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] c_ADDR_INSTRETH  = 12'hC82;
    localparam logic [11:0] c_ADDR_MHARTID   = 12'hF14;
    localparam logic [31:0] c_MSTATUS_MASK   = 32'h0000_0088;
    localparam logic [31:0] c_ALIGN_MASK     = 32'hFFFF_FFFC;

    logic [31:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [63:0] r_mcycle, r_minstret;
    logic        r_rsp_valid, r_rsp_illegal;
    logic [31:0] r_rsp_rdata;

    logic [31:0] w_old, w_src, w_new;
    logic        w_hit, w_is_op, w_illegal, w_fire, w_commit;

    // Read mux: old value of the addressed CSR, counters before this cycle's increment
    always_comb begin
        w_old = '0;
        w_hit = 1'b1;
        case (req_addr)
            c_ADDR_MSTATUS:                     w_old = r_mstatus;
            c_ADDR_MISA:                        w_old = MISA_VALUE;
            c_ADDR_MIE:                         w_old = r_mie;
            c_ADDR_MTVEC:                       w_old = r_mtvec;
            c_ADDR_MSCRATCH:                    w_old = r_mscratch;
            c_ADDR_MEPC:                        w_old = r_mepc;
            c_ADDR_MCAUSE:                      w_old = r_mcause;
            c_ADDR_MTVAL:                       w_old = r_mtval;
            c_ADDR_MCYCLE,   c_ADDR_CYCLE:      w_old = r_mcycle[31:0];
            c_ADDR_MCYCLEH,  c_ADDR_CYCLEH:     w_old = r_mcycle[63:32];
            c_ADDR_MINSTRET, c_ADDR_INSTRET:    w_old = r_minstret[31:0];
            c_ADDR_MINSTRETH, c_ADDR_INSTRETH:  w_old = r_minstret[63:32];
            c_ADDR_MHARTID:                     w_old = HART_ID;
            default:                            w_hit = 1'b0;
        endcase
    end

    assign w_src = (req_params.input_select == CSR_SRC_UIMM) ? {27'b0, req_uimm} : req_rs1_value;

    always_comb begin
        w_new = w_old;
        case (req_params.write_func)
            CSR_WRITE_RW: w_new = w_src;
            CSR_WRITE_RS: w_new = w_old | w_src;
            CSR_WRITE_RC: w_new = w_old & ~w_src;
            default:      w_new = w_old;
        endcase
    end

    assign req_ready = !r_rsp_valid | rsp_ready;
    assign w_fire    = req_valid & req_ready;
    assign w_is_op   = (req_params.write_func != CSR_WRITE_NONE);
    assign w_illegal = !w_hit | (req_params.write_enable & (req_addr[11:10] == 2'b11));
    assign w_commit  = w_fire & w_is_op & req_params.write_enable & !w_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus  <= '0;
            r_mie      <= '0;
            r_mtvec    <= MTVEC_RESET & c_ALIGN_MASK;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else if (w_commit) begin
            case (req_addr)
                c_ADDR_MSTATUS:  r_mstatus  <= w_new & c_MSTATUS_MASK;
                c_ADDR_MIE:      r_mie      <= w_new;
                c_ADDR_MTVEC:    r_mtvec    <= w_new & c_ALIGN_MASK;
                c_ADDR_MSCRATCH: r_mscratch <= w_new;
                c_ADDR_MEPC:     r_mepc     <= w_new & c_ALIGN_MASK;
                c_ADDR_MCAUSE:   r_mcause   <= w_new;
                c_ADDR_MTVAL:    r_mtval    <= w_new;
                default:         ;
            endcase
        end
    end

    // A written counter half replaces the increment for that cycle; the other half holds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcycle <= '0;
        end else if (w_commit && req_addr == c_ADDR_MCYCLE) begin
            r_mcycle[31:0] <= w_new;
        end else if (w_commit && req_addr == c_ADDR_MCYCLEH) begin
            r_mcycle[63:32] <= w_new;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_minstret <= '0;
        end else if (w_commit && req_addr == c_ADDR_MINSTRET) begin
            r_minstret[31:0] <= w_new;
        end else if (w_commit && req_addr == c_ADDR_MINSTRETH) begin
            r_minstret[63:32] <= w_new;
        end else begin
            r_minstret <= r_minstret + {63'd0, retire};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_illegal <= 1'b0;
        end else if (w_fire) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= (w_is_op && req_params.read_enable && !w_illegal) ? w_old : 32'd0;
            r_rsp_illegal <= w_is_op & w_illegal;
        end else if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_illegal = r_rsp_illegal;
    assign mstatus_mie = r_mstatus[3];
    assign mtvec_base  = r_mtvec;

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_csr_file
//  Description : Table vectors, directed corner sequences and random traffic
//                for csr_file, checked against a behavioural CSR model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_file;
    import csr_pkg::*;

    localparam logic [31:0] HART  = 32'h0000_0000;
    localparam logic [31:0] MISA  = 32'h4000_0100;
    localparam logic [31:0] MTVR  = 32'h0000_0103;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, retire, rsp_valid, rsp_ready, rsp_illegal, mstatus_mie;
    csr_params_t req_params;
    logic [11:0] req_addr;
    logic [31:0] req_rs1_value, rsp_rdata, mtvec_base;
    logic [4:0]  req_uimm;

    csr_file #(.HART_ID(HART), .MISA_VALUE(MISA), .MTVEC_RESET(MTVR)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_params(req_params), .req_addr(req_addr), .req_rs1_value(req_rs1_value),
        .req_uimm(req_uimm), .retire(retire), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal), .mstatus_mie(mstatus_mie),
        .mtvec_base(mtvec_base)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_csr [int];
    logic [63:0] m_cycle, m_instret;
    bit          m_valid, m_illegal;
    logic [31:0] m_rdata;

    function automatic bit m_known(input logic [11:0] a);
        case (a)
            12'h301, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
            12'hC00, 12'hC80, 12'hC02, 12'hC82: return 1'b1;
            default: return m_csr.exists(int'(a));
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h301:          return MISA;
            12'hF14:          return HART;
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02, 12'hC02: return m_instret[31:0];
            12'hB82, 12'hC82: return m_instret[63:32];
            default:          return m_csr.exists(int'(a)) ? m_csr[int'(a)] : 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_wmask(input logic [11:0] a);
        if (a == 12'h300) return 32'h0000_0088;
        if (a == 12'h305 || a == 12'h341) return 32'hFFFF_FFFC;
        return 32'hFFFF_FFFF;
    endfunction

    task automatic m_reset();
        m_csr.delete();
        m_csr[32'h300] = 0; m_csr[32'h304] = 0; m_csr[32'h305] = MTVR & 32'hFFFF_FFFC;
        m_csr[32'h340] = 0; m_csr[32'h341] = 0; m_csr[32'h342] = 0; m_csr[32'h343] = 0;
        m_cycle = 0; m_instret = 0;
        m_valid = 0; m_rdata = 0; m_illegal = 0;
    endtask

    // Predict what the coming rising edge does with the inputs now applied
    task automatic model_edge();
        logic [63:0] nc, ni;
        logic [31:0] old, src, nv;
        logic [11:0] a;
        bit legal;
        if (rst) begin
            m_reset();
            return;
        end
        nc = m_cycle + 1;
        ni = m_instret + (retire ? 64'd1 : 64'd0);
        a  = req_addr;
        if (req_valid && (!m_valid || rsp_ready)) begin
            m_valid = 1;
            if (req_params.write_func == CSR_WRITE_NONE) begin
                m_rdata = 0; m_illegal = 0;
            end else begin
                legal = m_known(a) && !(req_params.write_enable && a[11:10] == 2'b11);
                old = legal ? m_read(a) : 32'd0;
                m_rdata = (legal && req_params.read_enable) ? old : 32'd0;
                m_illegal = !legal;
                if (legal && req_params.write_enable) begin
                    src = (req_params.input_select == CSR_SRC_UIMM) ? {27'd0, req_uimm} : req_rs1_value;
                    if (req_params.write_func == CSR_WRITE_RW) nv = src;
                    else if (req_params.write_func == CSR_WRITE_RS) nv = old | src;
                    else nv = old & ~src;
                    case (a)
                        12'hB00: nc = {m_cycle[63:32], nv};
                        12'hB80: nc = {nv, m_cycle[31:0]};
                        12'hB02: ni = {m_instret[63:32], nv};
                        12'hB82: ni = {nv, m_instret[31:0]};
                        12'h301: ;
                        default: m_csr[int'(a)] = nv & m_wmask(a);
                    endcase
                end
            end
        end else if (rsp_ready) begin
            m_valid = 0;
        end
        m_cycle = nc;
        m_instret = ni;
    endtask

    task automatic step();
        logic [31:0] ms;
        #1;
        if (!rst) chk("req_ready", req_ready, (!m_valid || rsp_ready));
        model_edge();
        @(posedge clk);
        #1;
        ms = m_csr[32'h300];
        chk("rsp_valid", rsp_valid, m_valid);
        if (m_valid) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_illegal", rsp_illegal, m_illegal);
        end
        chk("mstatus_mie", mstatus_mie, ms[3]);
        chk("mtvec_base", mtvec_base, m_csr[32'h305]);
    endtask

    task automatic drive(input logic re, input logic we, input csr_src_e sel, input csr_write_func_e f,
                         input logic [11:0] a, input logic [31:0] rs1, input logic [4:0] u);
        req_params.read_enable  = re;
        req_params.write_enable = we;
        req_params.input_select = sel;
        req_params.write_func   = f;
        req_addr = a; req_rs1_value = rs1; req_uimm = u;
        req_valid = 1'b1;
    endtask

    task automatic txn(input logic re, input logic we, input csr_src_e sel, input csr_write_func_e f,
                       input logic [11:0] a, input logic [31:0] rs1, input logic [4:0] u);
        drive(re, we, sel, f, a, rs1, u);
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic re, we;
        csr_src_e sel;
        csr_write_func_e f;
        logic [11:0] a;
        logic [31:0] rs1;
        logic [4:0]  u;
        logic [31:0] exp_rdata;
        logic        exp_ill;
        logic [31:0] exp_mtvec;
        logic        exp_mie;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic re, input logic we, input csr_src_e sel, input csr_write_func_e f,
                       input logic [11:0] a, input logic [31:0] rs1, input logic [4:0] u,
                       input logic [31:0] er, input logic ei, input logic [31:0] et, input logic em);
        vec_t v;
        v.re = re; v.we = we; v.sel = sel; v.f = f; v.a = a; v.rs1 = rs1; v.u = u;
        v.exp_rdata = er; v.exp_ill = ei; v.exp_mtvec = et; v.exp_mie = em;
        tbl.push_back(v);
    endtask

    logic [11:0] addrs [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h302, 12'hB01};

    initial begin
        logic [31:0] exp;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; retire = 1'b0;
        req_params = '0; req_addr = '0; req_rs1_value = '0; req_uimm = '0;

        add(1,1,CSR_SRC_RS1, CSR_WRITE_RW,12'h340,32'hDEAD_BEEF,0,32'h0,        0,32'h100,0);
        add(1,0,CSR_SRC_RS1, CSR_WRITE_RS,12'h340,32'h0,       0,32'hDEAD_BEEF,0,32'h100,0);
        add(1,1,CSR_SRC_RS1, CSR_WRITE_RW,12'h340,32'hFF00_FF00,0,32'hDEAD_BEEF,0,32'h100,0);
        add(1,1,CSR_SRC_RS1, CSR_WRITE_RC,12'h340,32'h0F0F_0F0F,0,32'hFF00_FF00,0,32'h100,0);
        add(1,0,CSR_SRC_RS1, CSR_WRITE_RS,12'h340,32'h0,       0,32'hF000_F000,0,32'h100,0);
        add(0,1,CSR_SRC_UIMM,CSR_WRITE_RW,12'h305,32'h0,5'b10111,32'h0,     0,32'h14,0);
        add(1,0,CSR_SRC_RS1, CSR_WRITE_RS,12'h305,32'h0,       0,32'h14,       0,32'h14,0);
        add(1,1,CSR_SRC_RS1, CSR_WRITE_RW,12'h300,32'hFFFF_FFFF,0,32'h0,       0,32'h14,1);
        add(1,0,CSR_SRC_RS1, CSR_WRITE_RS,12'h300,32'h0,       0,32'h88,       0,32'h14,1);
        add(1,1,CSR_SRC_UIMM,CSR_WRITE_RC,12'h300,32'h0,       5'd8,32'h88,    0,32'h14,0);
        add(1,0,CSR_SRC_RS1, CSR_WRITE_RS,12'h300,32'h0,       0,32'h80,       0,32'h14,0);
        add(1,1,CSR_SRC_RS1, CSR_WRITE_RW,12'hC00,32'h0,       0,32'h0,        1,32'h14,0);
        add(1,1,CSR_SRC_RS1, CSR_WRITE_RW,12'h301,32'h0,       0,MISA,         0,32'h14,0);
        add(1,0,CSR_SRC_RS1, CSR_WRITE_RS,12'h301,32'h0,       0,MISA,         0,32'h14,0);
        add(1,1,CSR_SRC_RS1, CSR_WRITE_RW,12'hF14,32'h5,       0,32'h0,        1,32'h14,0);
        add(1,0,CSR_SRC_RS1, CSR_WRITE_RS,12'hF14,32'h0,       0,HART,         0,32'h14,0);
        add(1,0,CSR_SRC_RS1, CSR_WRITE_RS,12'h7C0,32'h0,       0,32'h0,        1,32'h14,0);
        add(1,1,CSR_SRC_RS1, CSR_WRITE_NONE,12'h7C0,32'hFFFF_FFFF,0,32'h0,     0,32'h14,0);
        add(1,1,CSR_SRC_RS1, CSR_WRITE_RW,12'h341,32'hFFFF_FFFF,0,32'h0,       0,32'h14,0);
        add(1,0,CSR_SRC_RS1, CSR_WRITE_RS,12'h341,32'h0,       0,32'hFFFF_FFFC,0,32'h14,0);
        add(1,1,CSR_SRC_UIMM,CSR_WRITE_RS,12'h340,32'h0,       5'h1F,32'hF000_F000,0,32'h14,0);
        add(1,0,CSR_SRC_RS1, CSR_WRITE_RS,12'h340,32'h0,       0,32'hF000_F01F,0,32'h14,0);

        step(); step();
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_mtvec", mtvec_base, 32'h100);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            txn(tbl[i].re, tbl[i].we, tbl[i].sel, tbl[i].f, tbl[i].a, tbl[i].rs1, tbl[i].u);
            chk($sformatf("tbl%0d_valid", i), rsp_valid, 1'b1);
            chk($sformatf("tbl%0d_rdata", i), rsp_rdata, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_illegal", i), rsp_illegal, tbl[i].exp_ill);
            chk($sformatf("tbl%0d_mtvec", i), mtvec_base, tbl[i].exp_mtvec);
            chk($sformatf("tbl%0d_mie", i), mstatus_mie, tbl[i].exp_mie);
        end

        // Read-only shadow read returns the cycle count before this edge
        exp = m_cycle[31:0];
        txn(1,0,CSR_SRC_RS1,CSR_WRITE_RS,12'hC00,32'h0,0);
        chk("cycle_read", rsp_rdata, exp);
        chk("cycle_read_legal", rsp_illegal, 1'b0);

        // Backpressure: response held, second request stalled, accepted on release
        req_valid = 1'b0; rsp_ready = 1'b1; step();
        drive(1,1,CSR_SRC_RS1,CSR_WRITE_RW,12'h340,32'h1111_1111,0);
        rsp_ready = 1'b0; step();
        drive(1,1,CSR_SRC_RS1,CSR_WRITE_RW,12'h340,32'h2222_2222,0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_req_ready", req_ready, 1'b0);
            chk("bp_rdata_held", rsp_rdata, 32'hF000_F01F);
        end
        rsp_ready = 1'b1; step(); req_valid = 1'b0;
        chk("bp_release_rdata", rsp_rdata, 32'h1111_1111);
        txn(1,0,CSR_SRC_RS1,CSR_WRITE_RS,12'h340,32'h0,0);
        chk("bp_final_value", rsp_rdata, 32'h2222_2222);

        // Counter carry into the high half, then write-over-increment
        txn(1,1,CSR_SRC_RS1,CSR_WRITE_RW,12'hB00,32'hFFFF_FFFF,0);
        txn(1,1,CSR_SRC_RS1,CSR_WRITE_RW,12'hB80,32'h0,0);
        step();
        txn(1,0,CSR_SRC_RS1,CSR_WRITE_RS,12'hB80,32'h0,0);
        chk("mcycleh_carry", rsp_rdata, 32'h1);
        txn(1,1,CSR_SRC_RS1,CSR_WRITE_RW,12'hB00,32'h100,0);
        txn(1,0,CSR_SRC_RS1,CSR_WRITE_RS,12'hB00,32'h0,0);
        chk("mcycle_write_wins", rsp_rdata, 32'h100);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            retire    = $urandom_range(0, 1);
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_valid = $urandom_range(0, 1);
            req_params.read_enable  = $urandom_range(0, 1);
            req_params.write_enable = $urandom_range(0, 1);
            req_params.input_select = csr_src_e'($urandom_range(0, 1));
            req_params.write_func   = csr_write_func_e'($urandom_range(0, 3));
            req_addr      = addrs[$urandom_range(0, 19)];
            req_rs1_value = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            req_uimm      = 5'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
